// File: rtl/clk_div_pkg.sv
// Shared constants and types for the multi-channel clock divider.
package clk_div_pkg;
  localparam int          CNT_W_DEF   = 24;
  localparam int unsigned DIV_RST_DEF = 16_250_000;

  typedef logic [CNT_W_DEF-1:0] div_cnt_t;
endpackage

// File: rtl/clk_div_ch.sv
// One divider channel: half-period counter, active limit, pending limit, clk_out/tick registers.
module clk_div_ch
  import clk_div_pkg::*;
#(
  parameter int               CNT_W   = CNT_W_DEF,
  parameter logic [CNT_W-1:0] DIV_RST = CNT_W'(DIV_RST_DEF)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sync_clr,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_val,
  output logic             pend,
  output logic             clk_out,
  output logic             tick
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] lim;
  logic [CNT_W-1:0] pend_val;
  logic             at_limit;
  logic             apply;

  // >= rather than == so a limit lowered below the live count still terminates.
  assign at_limit = (cnt >= lim);
  // A disabled channel has no boundary to wait for, so it takes the new limit at once.
  // sync_clr is never a boundary; the limit waits for the next real toggle.
  assign apply    = pend && !sync_clr && (!en || at_limit);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      lim      <= DIV_RST;
      pend_val <= '0;
      pend     <= 1'b0;
      clk_out  <= 1'b1;
      tick     <= 1'b0;
    end else begin
      tick <= 1'b0;

      // A write arriving on the apply cycle wins and stays pending to the next boundary.
      if (wr) begin
        pend_val <= wr_val;
        pend     <= 1'b1;
      end else if (apply) begin
        lim  <= pend_val;
        pend <= 1'b0;
      end

      if (sync_clr || !en) begin
        cnt     <= '0;
        clk_out <= 1'b1;
      end else if (at_limit) begin
        cnt     <= '0;
        clk_out <= ~clk_out;
        tick    <= ~clk_out;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/clk_div_multi.sv
// N-channel programmable clock divider / tick generator with boundary-safe divisor updates.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int          N_CH    = 4,
  parameter int          CNT_W   = CNT_W_DEF,
  parameter int unsigned DIV_RST = DIV_RST_DEF,
  localparam int         CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic [N_CH-1:0]  ch_en,
  input  logic             sync_clr,
  input  logic             div_wr_en,
  input  logic [CH_W-1:0]  div_wr_ch,
  input  logic [CNT_W-1:0] div_wr_val,
  output logic [N_CH-1:0]  div_pend,
  output logic [N_CH-1:0]  clk_out,
  output logic [N_CH-1:0]  tick
);

  // Out-of-range channel numbers match no decode bit, so the write simply vanishes.
  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic wr_hit;
    assign wr_hit = div_wr_en && (div_wr_ch == CH_W'(g));

    clk_div_ch #(
      .CNT_W   (CNT_W),
      .DIV_RST (CNT_W'(DIV_RST))
    ) u_ch (
      .clk      (clk_in),
      .rst      (rst),
      .en       (ch_en[g]),
      .sync_clr (sync_clr),
      .wr       (wr_hit),
      .wr_val   (div_wr_val),
      .pend     (div_pend[g]),
      .clk_out  (clk_out[g]),
      .tick     (tick[g])
    );
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed bench for clk_div_multi: half-periods, write/apply timing, enable, sync_clr, reset.
module tb_clk_div_multi;
  localparam int N_CH    = 5;
  localparam int CNT_W   = 8;
  localparam int DIV_RST = 6;
  localparam int CH_W    = 3;

  logic             clk_in = 1'b0;
  logic             rst;
  logic [N_CH-1:0]  ch_en;
  logic             sync_clr;
  logic             div_wr_en;
  logic [CH_W-1:0]  div_wr_ch;
  logic [CNT_W-1:0] div_wr_val;
  logic [N_CH-1:0]  div_pend;
  logic [N_CH-1:0]  clk_out;
  logic [N_CH-1:0]  tick;

  int total = 0;
  int bad   = 0;

  clk_div_multi #(.N_CH(N_CH), .CNT_W(CNT_W), .DIV_RST(DIV_RST)) dut (
    .clk_in     (clk_in),
    .rst        (rst),
    .ch_en      (ch_en),
    .sync_clr   (sync_clr),
    .div_wr_en  (div_wr_en),
    .div_wr_ch  (div_wr_ch),
    .div_wr_val (div_wr_val),
    .div_pend   (div_pend),
    .clk_out    (clk_out),
    .tick       (tick)
  );

  always #5 clk_in = ~clk_in;

  // Advance one clock; outputs are stable and new inputs may be driven on return.
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  // Steps until clk_out[ch] changes; returns the step count (bounded).
  task automatic count_to_change(input int ch, output int n);
    logic old;
    old = clk_out[ch];
    n = 0;
    while (clk_out[ch] === old && n < 2000) begin
      step();
      n++;
    end
  endtask

  // Write to a disabled channel: pending for one cycle, applied on the next.
  task automatic load_idle(input int ch, input int val);
    div_wr_en = 1'b1; div_wr_ch = CH_W'(ch); div_wr_val = CNT_W'(val);
    step();
    div_wr_en = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1; ch_en = '0; sync_clr = 1'b0;
    div_wr_en = 1'b0; div_wr_ch = '0; div_wr_val = '0;
    step(); step();
    rst = 1'b0;
    total++;
    if (clk_out !== 5'h1f || tick !== 5'h00 || div_pend !== 5'h00) begin
      bad++;
      $display("FAIL reset: clk_out=%h tick=%h pend=%h want 1f/00/00", clk_out, tick, div_pend);
    end
  endtask

  task automatic test_basic();
    int n;
    div_wr_en = 1'b1; div_wr_ch = 0; div_wr_val = 8'd3;
    step();
    div_wr_en = 1'b0;
    total++;
    if (div_pend[0] !== 1'b1) begin bad++; $display("FAIL idle_pend_set: got %b want 1", div_pend[0]); end
    step();
    total++;
    if (div_pend[0] !== 1'b0) begin bad++; $display("FAIL idle_apply: got %b want 0", div_pend[0]); end
    ch_en[0] = 1'b1;
    count_to_change(0, n);
    total++;
    if (n !== 4 || tick[0] !== 1'b0) begin bad++; $display("FAIL basic_first_fall: n=%0d tick=%b want 4/0", n, tick[0]); end
    count_to_change(0, n);
    total++;
    if (n !== 4 || tick[0] !== 1'b1) begin bad++; $display("FAIL basic_first_rise: n=%0d tick=%b want 4/1", n, tick[0]); end
    step();
    total++;
    if (tick[0] !== 1'b0) begin bad++; $display("FAIL tick_width: got %b want 0", tick[0]); end
    count_to_change(0, n);
    total++;
    if (n !== 3) begin bad++; $display("FAIL basic_high_rest: n=%0d want 3", n); end
    count_to_change(0, n);
    total++;
    if (n !== 4 || tick[0] !== 1'b1) begin bad++; $display("FAIL basic_period: n=%0d tick=%b want 4/1", n, tick[0]); end
  endtask

  task automatic test_midwrite();
    int n;
    load_idle(1, 3);
    ch_en[1] = 1'b1;
    count_to_change(1, n);
    total++;
    if (n !== 4) begin bad++; $display("FAIL mid_setup_fall: n=%0d want 4", n); end
    div_wr_en = 1'b1; div_wr_ch = 1; div_wr_val = 8'd1;
    step();
    div_wr_en = 1'b0;
    total++;
    if (div_pend[1] !== 1'b1) begin bad++; $display("FAIL mid_pend_set: got %b want 1", div_pend[1]); end
    count_to_change(1, n);
    total++;
    if (n !== 3 || div_pend[1] !== 1'b0) begin bad++; $display("FAIL mid_old_half: n=%0d pend=%b want 3/0", n, div_pend[1]); end
    count_to_change(1, n);
    total++;
    if (n !== 2) begin bad++; $display("FAIL mid_new_half1: n=%0d want 2", n); end
    count_to_change(1, n);
    total++;
    if (n !== 2) begin bad++; $display("FAIL mid_new_half2: n=%0d want 2", n); end
  endtask

  task automatic test_back_to_back();
    int n;
    load_idle(2, 3);
    ch_en[2] = 1'b1;
    count_to_change(2, n);
    div_wr_en = 1'b1; div_wr_ch = 2; div_wr_val = 8'd5;
    step();
    div_wr_val = 8'd2;
    step();
    div_wr_en = 1'b0;
    total++;
    if (div_pend[2] !== 1'b1) begin bad++; $display("FAIL b2b_pend: got %b want 1", div_pend[2]); end
    count_to_change(2, n);
    total++;
    if (n !== 2 || div_pend[2] !== 1'b0) begin bad++; $display("FAIL b2b_old_half: n=%0d pend=%b want 2/0", n, div_pend[2]); end
    count_to_change(2, n);
    total++;
    if (n !== 3 || div_pend[2] !== 1'b0) begin bad++; $display("FAIL b2b_last_wins: n=%0d pend=%b want 3/0", n, div_pend[2]); end
  endtask

  task automatic test_sync_clr();
    int n;
    ch_en = '0;
    step();
    load_idle(1, 5);
    ch_en[1:0] = 2'b11;
    step(); step();
    // ch0 cnt=2: a write now is captured, then sync_clr lands on ch0's toggle cycle.
    div_wr_en = 1'b1; div_wr_ch = 0; div_wr_val = 8'd1;
    step();
    div_wr_en = 1'b0;
    sync_clr = 1'b1;
    step();
    sync_clr = 1'b0;
    total++;
    if (clk_out[1:0] !== 2'b11 || tick[1:0] !== 2'b00 || div_pend[0] !== 1'b1) begin
      bad++;
      $display("FAIL sync_state: clk=%b tick=%b pend0=%b want 11/00/1", clk_out[1:0], tick[1:0], div_pend[0]);
    end
    count_to_change(0, n);
    total++;
    if (n !== 4 || clk_out[1] !== 1'b1 || div_pend[0] !== 1'b0) begin
      bad++;
      $display("FAIL sync_ch0_fall: n=%0d clk1=%b pend0=%b want 4/1/0", n, clk_out[1], div_pend[0]);
    end
    count_to_change(1, n);
    total++;
    if (n !== 2 || clk_out[0] !== 1'b1) begin bad++; $display("FAIL sync_ch1_fall: n=%0d clk0=%b want 2/1", n, clk_out[0]); end
  endtask

  task automatic test_enable();
    int n;
    load_idle(3, 2);
    ch_en[3] = 1'b1;
    count_to_change(3, n);
    total++;
    if (n !== 3 || clk_out[3] !== 1'b0) begin bad++; $display("FAIL en_fall: n=%0d clk=%b want 3/0", n, clk_out[3]); end
    ch_en[3] = 1'b0;
    step();
    total++;
    if (clk_out[3] !== 1'b1 || tick[3] !== 1'b0) begin bad++; $display("FAIL en_off: clk=%b tick=%b want 1/0", clk_out[3], tick[3]); end
    step();
    ch_en[3] = 1'b1;
    count_to_change(3, n);
    total++;
    if (n !== 3 || clk_out[3] !== 1'b0) begin bad++; $display("FAIL en_refall: n=%0d clk=%b want 3/0", n, clk_out[3]); end
  endtask

  task automatic test_max_limit();
    int n;
    load_idle(4, 255);
    ch_en[4] = 1'b1;
    count_to_change(4, n);
    total++;
    if (n !== 256) begin bad++; $display("FAIL max_fall: n=%0d want 256", n); end
    count_to_change(4, n);
    total++;
    if (n !== 256 || tick[4] !== 1'b1) begin bad++; $display("FAIL max_rise: n=%0d tick=%b want 256/1", n, tick[4]); end
  endtask

  task automatic test_bad_ch_and_reset();
    int n;
    div_wr_en = 1'b1; div_wr_ch = 3'd5; div_wr_val = 8'd1;
    step();
    div_wr_ch = 3'd7;
    step();
    div_wr_en = 1'b0;
    total++;
    if (div_pend !== 5'h00) begin bad++; $display("FAIL bad_ch: pend=%h want 00", div_pend); end
    div_wr_en = 1'b1; div_wr_ch = 0; div_wr_val = 8'd9;
    step();
    div_wr_en = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++;
    if (clk_out !== 5'h1f || tick !== 5'h00 || div_pend !== 5'h00) begin
      bad++;
      $display("FAIL mid_reset: clk_out=%h tick=%h pend=%h want 1f/00/00", clk_out, tick, div_pend);
    end
    ch_en = 5'h01;
    count_to_change(0, n);
    total++;
    if (n !== DIV_RST + 1) begin bad++; $display("FAIL reset_lim: n=%0d want %0d", n, DIV_RST + 1); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_midwrite();
    test_back_to_back();
    test_sync_clr();
    test_enable();
    test_max_limit();
    test_bad_ch_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
